// File: rtl/iq_pkg.sv
// Shared payload field positions and widths for the issue queue.
package iq_pkg;

  localparam int unsigned PREG_W        = 6;
  localparam int unsigned ROB_W         = 6;

  localparam int unsigned IMM_SRC_BIT   = 97;
  localparam int unsigned SRC2_RDY_BIT  = 89;
  localparam int unsigned SRC2_PREG_MSB = 88;
  localparam int unsigned SRC2_PREG_LSB = 83;
  localparam int unsigned SRC1_RDY_BIT  = 82;
  localparam int unsigned SRC1_PREG_MSB = 81;
  localparam int unsigned SRC1_PREG_LSB = 76;
  localparam int unsigned ROB_MSB       = 37;
  localparam int unsigned ROB_LSB       = 32;

endpackage

// File: rtl/iq_oldest_select.sv
// Priority encoder: finds the lowest-index (oldest) ready entry.
module iq_oldest_select #(
  parameter int unsigned DEPTH = 8,
  parameter int unsigned IDX_W = 3
) (
  input  logic [DEPTH-1:0] ready,
  output logic             found,
  output logic [IDX_W-1:0] idx
);

  // Scan from the top so the lowest set bit wins.
  always_comb begin
    found = 1'b0;
    idx   = '0;
    for (int i = int'(DEPTH) - 1; i >= 0; i--) begin
      if (ready[i]) begin
        found = 1'b1;
        idx   = IDX_W'(i);
      end
    end
  end

endmodule

// File: rtl/issue_queue.sv
// Compacting out-of-order issue queue: entry 0 is oldest, valid entries are
// contiguous from 0, writeback snooping wakes sources, oldest ready issues.
module issue_queue
  import iq_pkg::*;
#(
  parameter int unsigned PAYLOAD_W = 137,
  parameter int unsigned DEPTH     = 8,
  parameter int unsigned CNT_W     = 4
) (
  input  logic                 CLK,
  input  logic                 RESET,
  input  logic                 FREEZE,
  input  logic                 FLUSH,
  input  logic                 push_valid,
  input  logic [PAYLOAD_W-1:0] push_data,
  output logic                 full,
  input  logic                 wb_flag,
  input  logic [PREG_W-1:0]    wb_index,
  output logic                 pop_valid,
  output logic [PAYLOAD_W-1:0] pop_data,
  output logic [CNT_W-1:0]     count
);

  localparam int unsigned IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [PAYLOAD_W-1:0] mem_q        [DEPTH];
  logic [PAYLOAD_W-1:0] mem_d        [DEPTH];
  logic [PAYLOAD_W-1:0] woken_c      [DEPTH];
  logic [PAYLOAD_W-1:0] push_woken_c;
  logic [PAYLOAD_W-1:0] issue_data_c;
  logic [CNT_W-1:0]     count_q;
  logic [CNT_W-1:0]     count_d;
  logic [CNT_W-1:0]     tail_c;
  logic [DEPTH-1:0]     valid_c;
  logic [DEPTH-1:0]     ready_c;
  logic                 sel_found;
  logic [IDX_W-1:0]     sel_idx;
  logic                 issue_c;
  logic                 push_acc_c;

  // Apply the current writeback broadcast to a payload's source-ready bits.
  function automatic logic [PAYLOAD_W-1:0] wake(
    input logic [PAYLOAD_W-1:0] p,
    input logic                 flag,
    input logic [PREG_W-1:0]    idx
  );
    logic [PAYLOAD_W-1:0] r;
    r = p;
    if (flag && (p[SRC1_PREG_MSB:SRC1_PREG_LSB] == idx)) r[SRC1_RDY_BIT] = 1'b1;
    if (flag && (p[SRC2_PREG_MSB:SRC2_PREG_LSB] == idx)) r[SRC2_RDY_BIT] = 1'b1;
    return r;
  endfunction

  assign full       = (count_q == CNT_W'(DEPTH));
  assign count      = count_q;
  assign push_acc_c = push_valid && !full && !FLUSH;
  assign issue_c    = sel_found && !FREEZE && !FLUSH;

  // Per-entry valid (from occupancy), readiness and woken copies.
  always_comb begin
    push_woken_c = wake(push_data, wb_flag, wb_index);
    for (int unsigned i = 0; i < DEPTH; i++) begin
      valid_c[i] = (count_q > CNT_W'(i));
      ready_c[i] = valid_c[i] && mem_q[i][SRC1_RDY_BIT] &&
                   (mem_q[i][SRC2_RDY_BIT] || mem_q[i][IMM_SRC_BIT]);
      woken_c[i] = wake(mem_q[i], wb_flag, wb_index);
    end
  end

  iq_oldest_select #(
    .DEPTH (DEPTH),
    .IDX_W (IDX_W)
  ) u_select (
    .ready (ready_c),
    .found (sel_found),
    .idx   (sel_idx)
  );

  // Next array contents: wakeup everywhere, compact over the issued slot,
  // then drop the accepted push at the post-shift tail.
  always_comb begin
    tail_c       = count_q - CNT_W'(issue_c);
    issue_data_c = '0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      mem_d[i] = woken_c[i];
      if (IDX_W'(i) == sel_idx) issue_data_c = woken_c[i];
    end
    if (issue_c) begin
      for (int unsigned i = 0; i + 1 < DEPTH; i++) begin
        if (CNT_W'(i) >= CNT_W'(sel_idx)) mem_d[i] = woken_c[i+1];
      end
    end
    if (push_acc_c) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        if (CNT_W'(i) == tail_c) mem_d[i] = push_woken_c;
      end
    end
    if (FLUSH) begin
      count_d = '0;
    end else begin
      count_d = count_q + CNT_W'(push_acc_c) - CNT_W'(issue_c);
    end
  end

  // Entry storage and occupancy.
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      count_q <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      count_q <= count_d;
      mem_q   <= mem_d;
    end
  end

  // Registered issue port; holds under FREEZE, cleared by FLUSH.
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      pop_valid <= 1'b0;
      pop_data  <= '0;
    end else if (FLUSH) begin
      pop_valid <= 1'b0;
    end else if (!FREEZE) begin
      pop_valid <= sel_found;
      if (sel_found) pop_data <= issue_data_c;
    end
  end

endmodule

// File: doc/issue_queue.md
Name: issue_queue

Overview:
- Out-of-order issue queue for non-memory instructions. It sits between rename/dispatch and the register-read stage.
- Holds dispatched payloads until their source physical registers are ready. Snoops the writeback broadcast to wake entries.
- Each cycle it selects the oldest ready entry and presents it, registered, as the pop payload and valid strobe consumed by register read.
- Memory ops go to the LSQ, not here.

Parameters:
- PAYLOAD_W, 137, width of a dispatch/issue payload (bits 136:0).
- DEPTH, 8, number of queue entries (2..16).
- CNT_W, 4, width of the occupancy count; must hold the value DEPTH.

Ports:
- CLK  in  1  clock.
- RESET  in  1  reset, asynchronous, active-low.
- FREEZE  in  1  pipeline stall; see Behaviour.
- FLUSH  in  1  mispredict squash; empties the queue.
- push_valid  in  1  dispatch offers an entry.
- push_data  in  PAYLOAD_W  dispatch payload.
- full  out  1  queue cannot accept a push this cycle (combinational from count).
- wb_flag  in  1  writeback valid, same signal that writes the register file.
- wb_index  in  6  physical register being written.
- pop_valid  out  1  registered; drives the register-read valid input.
- pop_data  out  PAYLOAD_W  registered; drives the register-read payload input.
- count  out  CNT_W  current occupancy.

Behaviour:
- Payload fields:
  - 97 imm-src
  - 89 src2 ready
  - 88:83 src2 preg
  - 82 src1 ready
  - 81:76 src1 preg
  - 37:32 ROB index
- Storage is a compacting array: entry 0 is the oldest; valid entries are contiguous from 0.
- Reset (async, RESET=0): all valid bits 0, count=0, pop_valid=0, pop_data=0.
- Accept: push accepted when push_valid && !full && !FLUSH. full = (count==DEPTH). A push is refused when full, even if an issue happens in the same cycle.
- Entry ready = valid && src1rdy && (src2rdy || imm-src).
- Wakeup, every cycle that wb_flag=1, including cycles with FREEZE=1:
  - Any stored entry with src1 preg == wb_index sets src1rdy; likewise for src2.
  - A payload pushed in the same cycle gets the same comparison before it is written (wakeup bypass).
  - wb_index 0 is treated like any other index.
- Select/issue, only when FREEZE=0 and FLUSH=0:
  - Pick the lowest-index ready entry.
  - Next edge: pop_data <= that entry's payload with the current-cycle wakeup applied to its ready bits; pop_valid <= 1.
  - Entries above it shift down by one; a new push lands at the tail after the shift.
  - If no entry is ready: pop_valid <= 0 and pop_data holds its value.
- Issue latency: an entry pushed with both sources ready issues at the earliest on the edge after it is stored (2 edges after push_valid is presented).
- FREEZE=1: pop_valid/pop_data hold, no issue, no shift. Pushes are still accepted and wakeups still recorded.
- FLUSH=1: next edge clears all valid bits, count=0, pop_valid=0. Overrides push, issue and FREEZE.
- Simultaneous push+issue: count unchanged. Push only: +1. Issue only: -1.
- count never exceeds DEPTH and never wraps.

Decomposition:
- Shared package iq_pkg:
  - payload bit-position constants (IMM_SRC_BIT=97, SRC2_RDY_BIT=89, SRC2_PREG_MSB/LSB=88/83, SRC1_RDY_BIT=82, SRC1_PREG_MSB/LSB=81/76, ROB_MSB/LSB=37/32);
  - PREG_W=6.
- One sub-module: iq_oldest_select. Priority encoder taking a DEPTH-bit ready vector; outputs the found flag and the lowest set index.

Test Plan:
- Reset mid-operation: 3 entries held, RESET low for one cycle -> immediately pop_valid=0, count=0, full=0.
- Push src1=5 (rdy=1), src2=9 (rdy=0), imm-src=0 -> no issue. Then wb_flag=1 with wb_index=9 -> issues on the following edge with pop_data[89]=1.
- Same-cycle bypass: push with src1=12 not ready while wb_index=12, wb_flag=1 -> entry stored ready and issues on the next edge.
- Age order: push A (src not ready), B ready, C ready -> B then C issue. Then wake A -> A issues. ROB fields seen on the pop side in order B, C, A.
- Fill with 8 unready entries -> full=1 and a 9th push is ignored (count stays 8). Wake one entry -> it issues, count=7, full=0.
- FREEZE=1 for 3 cycles with ready entries -> pop_data/pop_valid held and wakeups still recorded. FLUSH during FREEZE -> count=0 and pop_valid=0 next edge.
